// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } req_t;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait counter; expired goes high once MAX_WAIT un-acked cycles have elapsed.
module mem_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == 8'(MAX_WAIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between fetch and load/store ports.
// One transaction in flight at a time; a silent memory is converted into an error response.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack
);

  state_t            state;
  req_t              last_grant;
  logic              if_elig;
  logic              d_elig;
  logic              grant_d;
  logic              grant_i;
  logic              busy;
  logic              expired;
  logic              timed_out;
  logic              done;
  logic [DATA_W-1:0] resp_data;

  // A requester still holds req during its own ack cycle, so mask it there.
  assign if_elig   = if_req & ~if_ack;
  assign d_elig    = d_req & ~d_ack;
  assign grant_d   = d_elig & (~if_elig | (last_grant == REQ_FETCH));
  assign grant_i   = if_elig & ~grant_d;
  assign busy      = (state != IDLE);
  assign timed_out = busy & ~mem_ack & expired;
  assign done      = busy & (mem_ack | expired);
  assign resp_data = timed_out ? DATA_W'(TIMEOUT_RDATA) : mem_rdata;

  mem_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (~busy),
    .enable (busy & ~mem_ack),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= REQ_FETCH;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      err        <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_be    <= d_be;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            state     <= BUSY_D;
          end else if (grant_i) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_be    <= '1;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            state     <= BUSY_I;
          end
        end
        BUSY_I, BUSY_D: begin
          if (done) begin
            mem_req <= 1'b0;
            err     <= timed_out;
            state   <= IDLE;
            if (state == BUSY_I) begin
              if_ack     <= 1'b1;
              if_rdata   <= resp_data;
              last_grant <= REQ_FETCH;
            end else begin
              d_ack      <= 1'b1;
              // Completed stores return zero; a timed-out store still reports the marker.
              d_rdata    <= (mem_we && !timed_out) ? '0 : resp_data;
              last_grant <= REQ_DATA;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// traffic run checked against a transaction-level memory and round-robin model.
module tb_mem_port_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              d_req;
  logic              d_we;
  logic [3:0]        d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              err;
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] mem_array [16];
  int mem_lat  = 1;
  bit mem_hang = 1'b0;
  bit spurious = 1'b0;
  int wcnt     = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // Memory model: acks mem_lat cycles after seeing mem_req, or never when hung.
  initial begin : responder
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_ack) begin
        mem_ack = 1'b0;
        wcnt    = 0;
      end else if (spurious) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        spurious  = 1'b0;
      end else if (mem_req) begin
        if (!mem_hang && wcnt >= mem_lat - 1) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            mem_rdata = $urandom;
            for (int b = 0; b < 4; b++)
              if (mem_be[b]) mem_array[mem_addr[5:2]][8*b +: 8] = mem_wdata[8*b +: 8];
          end else begin
            mem_rdata = mem_array[mem_addr[5:2]];
          end
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_be = '0; d_addr = '0; d_wdata = '0;
    tick(); tick();
    n_cmp++;
    if ({mem_req, if_ack, d_ack, err, mem_we} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {mem_req, if_ack, d_ack, err, mem_we});
    end
    n_cmp++;
    if ({mem_be, mem_addr, mem_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_payload: got be=%h addr=%h wdata=%h expected all 0", mem_be, mem_addr, mem_wdata);
    end
    n_cmp++;
    if ({if_rdata, d_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_rdata: got if=%h d=%h expected 0", if_rdata, d_rdata);
    end
    reset = 1'b0;
    tick();
    $display("reset: outputs checked");
  endtask

  task automatic test_single_fetch();
    mem_array[0] = 32'h0000_0013; mem_lat = 1; mem_hang = 1'b0;
    if_addr = 32'h0001_0000; if_req = 1'b1;
    tick();
    n_cmp++;
    if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h0001_0000}) begin
      n_fail++; $display("FAIL fetch_grant: got req=%b we=%b be=%h addr=%h expected 1 0 f 00010000", mem_req, mem_we, mem_be, mem_addr);
    end
    tick();
    n_cmp++;
    if ({if_ack, d_ack, err} !== 3'b100 || if_rdata !== 32'h13) begin
      n_fail++; $display("FAIL fetch_ack: got ack=%b dack=%b err=%b rdata=%h expected 1 0 0 00000013", if_ack, d_ack, err, if_rdata);
    end
    if_req = 1'b0;
    tick();
    n_cmp++;
    if ({if_ack, mem_req} !== 2'b00) begin
      n_fail++; $display("FAIL fetch_pulse: got ack=%b mem_req=%b expected 0 0", if_ack, mem_req);
    end
    $display("fetch: addr=00010000 rdata=%h err=%b", if_rdata, err);
  endtask

  task automatic test_single_store();
    mem_lat = 1;
    d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h100; d_wdata = 32'h0000_A5A5; d_req = 1'b1;
    tick();
    n_cmp++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h100, 32'h0000_A5A5}) begin
      n_fail++; $display("FAIL store_grant: got req=%b we=%b be=%b addr=%h wdata=%h expected 1 1 0011 00000100 0000a5a5", mem_req, mem_we, mem_be, mem_addr, mem_wdata);
    end
    tick();
    n_cmp++;
    if ({d_ack, if_ack, err} !== 3'b100 || d_rdata !== 32'h0) begin
      n_fail++; $display("FAIL store_ack: got ack=%b iack=%b err=%b rdata=%h expected 1 0 0 00000000", d_ack, if_ack, err, d_rdata);
    end
    d_req = 1'b0;
    tick();
    n_cmp++;
    if (mem_array[0] !== 32'h0000_A5A5) begin
      n_fail++; $display("FAIL store_bytes: got mem=%h expected 0000a5a5", mem_array[0]);
    end
    $display("store: addr=00000100 be=0011 wdata=0000a5a5");
  endtask

  task automatic test_back_to_back();
    bit exp_d, exp_i;
    do_reset();
    mem_lat = 1;
    if_addr = 32'h40; d_we = 1'b0; d_addr = 32'h80;
    if_req = 1'b1; d_req = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      exp_d = (t == 2 || t == 6);
      exp_i = (t == 4 || t == 8);
      n_cmp++;
      if ({d_ack, if_ack} !== {exp_d, exp_i}) begin
        n_fail++; $display("FAIL b2b_order cycle %0d: got d_ack=%b if_ack=%b expected %b %b", t, d_ack, if_ack, exp_d, exp_i);
      end
      if (exp_d || exp_i) $display("b2b: cycle %0d %s ack", t, exp_d ? "data" : "fetch");
    end
    if_req = 1'b0; d_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_timeout();
    int k;
    mem_hang = 1'b1;
    if_addr = 32'h0000_0C00; if_req = 1'b1;
    for (int w = 0; w < 5 && !mem_req; w++) tick();
    for (k = 1; k <= 40; k++) begin
      tick();
      if (if_ack) break;
    end
    n_cmp++;
    if (k !== MAX_WAIT + 1 || err !== 1'b1 || if_rdata !== 32'hDEAD_BEEF || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL timeout_fetch: got cycle=%0d err=%b rdata=%h mem_req=%b expected %0d 1 deadbeef 0", k, err, if_rdata, mem_req, MAX_WAIT + 1);
    end
    $display("timeout: fetch after %0d cycles rdata=%h err=%b", k, if_rdata, err);
    if_req = 1'b0; mem_hang = 1'b0;
    tick();
    n_cmp++;
    if ({if_ack, err, mem_req} !== 3'b000) begin
      n_fail++; $display("FAIL timeout_idle: got ack=%b err=%b mem_req=%b expected 0 0 0", if_ack, err, mem_req);
    end
    // Ack landing exactly on the limit completes normally; one cycle later is a timeout.
    for (int c = 0; c < 2; c++) begin
      mem_lat = MAX_WAIT + 1 + c;
      mem_array[3] = 32'hCAFE_0000 + c;
      d_we = 1'b0; d_addr = 32'h0000_000C; d_req = 1'b1;
      for (int w = 0; w < 5 && !mem_req; w++) tick();
      for (k = 1; k <= 40; k++) begin
        tick();
        if (d_ack) break;
      end
      n_cmp++;
      if (k !== MAX_WAIT + 1 || err !== (c == 1) || d_rdata !== ((c == 1) ? 32'hDEAD_BEEF : 32'hCAFE_0000)) begin
        n_fail++; $display("FAIL timeout_edge lat=%0d: got cycle=%0d err=%b rdata=%h expected %0d %b %h", mem_lat, k, err, d_rdata, MAX_WAIT + 1, (c == 1), (c == 1) ? 32'hDEAD_BEEF : 32'hCAFE_0000);
      end
      $display("timeout_edge: lat=%0d ack cycle=%0d err=%b rdata=%h", mem_lat, k, err, d_rdata);
      d_req = 1'b0;
      tick(); tick();
    end
    mem_lat = 1;
  endtask

  task automatic test_reset_mid();
    bit seen;
    mem_hang = 1'b1; mem_array[5] = 32'h5555_1234;
    d_we = 1'b0; d_addr = 32'h14; d_req = 1'b1;
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    n_cmp++;
    if (mem_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_memreq: got %b expected 0", mem_req);
    end
    seen = 1'b0;
    for (int w = 0; w < 2; w++) begin
      tick();
      if (d_ack) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_fail++; $display("FAIL reset_mid_noack: got d_ack during reset expected none");
    end
    reset = 1'b0; mem_hang = 1'b0; mem_lat = 2;
    seen = 1'b0;
    for (int w = 0; w < 10 && !seen; w++) begin
      tick();
      if (d_ack) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || err !== 1'b0 || d_rdata !== 32'h5555_1234) begin
      n_fail++; $display("FAIL reset_mid_retry: got ack=%b err=%b rdata=%h expected 1 0 55551234", seen, err, d_rdata);
    end
    $display("reset_mid: retried load rdata=%h", d_rdata);
    d_req = 1'b0; mem_lat = 1;
    tick();
  endtask

  task automatic test_spurious_ack();
    bit bad;
    if_req = 1'b0; d_req = 1'b0;
    spurious = 1'b1;
    bad = 1'b0;
    for (int w = 0; w < 3; w++) begin
      tick();
      if ({if_ack, d_ack, err, mem_req} !== 4'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_fail++; $display("FAIL spurious_ack: got activity on ack/err/mem_req expected none");
    end
    mem_array[1] = 32'h0BAD_F00D;
    if_addr = 32'h4; if_req = 1'b1;
    tick();
    n_cmp++;
    if (mem_req !== 1'b1) begin
      n_fail++; $display("FAIL spurious_idle: got mem_req=%b expected 1", mem_req);
    end
    tick();
    n_cmp++;
    if (if_ack !== 1'b1 || if_rdata !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL spurious_after: got ack=%b rdata=%h expected 1 0badf00d", if_ack, if_rdata);
    end
    $display("spurious: ignored, following fetch rdata=%h", if_rdata);
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] ref_mem [16];
    bit          i_act = 1'b0, d_act = 1'b0;
    bit          ack_i_prev = 1'b0, ack_d_prev = 1'b0, mem_req_prev = 1'b0;
    bit          last_data = 1'b0, granted_data = 1'b0;
    bit          el_i, el_d, exp_data, ok;
    logic [31:0] i_a, d_a, d_wd, exp_rd;
    logic        d_w;
    logic [3:0]  d_b;
    int          i_age = 0, d_age = 0, n_txn = 0;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      mem_array[k] = $urandom;
      ref_mem[k]   = mem_array[k];
    end
    i_a = '0; d_a = '0; d_wd = '0; d_w = 1'b0; d_b = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      mem_lat = $urandom_range(1, 4);
      tick();
      if (mem_req && !mem_req_prev) begin
        el_i     = if_req && !ack_i_prev;
        el_d     = d_req && !ack_d_prev;
        exp_data = (el_i && el_d) ? !last_data : el_d;
        if (exp_data)
          ok = (mem_we === d_w) && (mem_addr === d_a) && (!d_w || (mem_be === d_b && mem_wdata === d_wd));
        else
          ok = (mem_we === 1'b0) && (mem_addr === i_a) && (mem_be === 4'hF);
        n_cmp++;
        if (!(el_i || el_d) || !ok) begin
          n_fail++; $display("FAIL rand_grant cyc %0d: got we=%b be=%h addr=%h wdata=%h expected %s grant (elig i=%b d=%b)", cyc, mem_we, mem_be, mem_addr, mem_wdata, exp_data ? "data" : "fetch", el_i, el_d);
        end
        granted_data = exp_data;
        if (exp_data) begin
          d_addr = $urandom; d_wdata = $urandom;
        end
      end
      if (if_ack) begin
        n_cmp++;
        if (!i_act || granted_data || if_rdata !== ref_mem[i_a[5:2]] || err !== 1'b0) begin
          n_fail++; $display("FAIL rand_fetch cyc %0d: got rdata=%h err=%b expected %h 0", cyc, if_rdata, err, ref_mem[i_a[5:2]]);
        end
        $display("txn %0d: fetch addr=%h rdata=%h", n_txn, i_a, if_rdata);
        i_act = 1'b0; last_data = 1'b0; n_txn++;
      end
      if (d_ack) begin
        exp_rd = d_w ? 32'h0 : ref_mem[d_a[5:2]];
        n_cmp++;
        if (!d_act || !granted_data || d_rdata !== exp_rd || err !== 1'b0) begin
          n_fail++; $display("FAIL rand_data cyc %0d: got rdata=%h err=%b expected %h 0", cyc, d_rdata, err, exp_rd);
        end
        if (d_w)
          for (int b = 0; b < 4; b++)
            if (d_b[b]) ref_mem[d_a[5:2]][8*b +: 8] = d_wd[8*b +: 8];
        $display("txn %0d: %s addr=%h be=%b wdata=%h rdata=%h", n_txn, d_w ? "store" : "load", d_a, d_b, d_wd, d_rdata);
        d_act = 1'b0; last_data = 1'b1; n_txn++;
      end
      ack_i_prev = if_ack; ack_d_prev = d_ack; mem_req_prev = mem_req;
      if (i_act) i_age++;
      if (d_act) d_age++;
      if (i_age > 60 || d_age > 60) begin
        n_cmp++; n_fail++;
        $display("FAIL rand_starve cyc %0d: got ages i=%0d d=%0d expected completion within 60", cyc, i_age, d_age);
        i_act = 1'b0; d_act = 1'b0; i_age = 0; d_age = 0;
      end
      if (!i_act && $urandom_range(0, 1) == 1) begin
        i_a = $urandom & 32'hFFFF_FFFC; i_act = 1'b1; i_age = 0;
        if_addr = i_a;
      end
      if (!d_act && $urandom_range(0, 1) == 1) begin
        d_w = 1'(($urandom_range(0, 1))); d_b = 4'($urandom_range(0, 15));
        d_a = $urandom & 32'hFFFF_FFFC; d_wd = $urandom; d_act = 1'b1; d_age = 0;
        d_we = d_w; d_be = d_b; d_addr = d_a; d_wdata = d_wd;
      end
      if_req = i_act;
      d_req  = d_act;
    end
    n_cmp++;
    if (n_txn < 100) begin
      n_fail++; $display("FAIL rand_throughput: got %0d transactions expected at least 100", n_txn);
    end
    if_req = 1'b0; d_req = 1'b0;
    do_reset();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    test_reset();
    test_single_fetch();
    test_single_store();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_spurious_ack();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
